// File: rtl/hazard_ctrl_if.sv
// ID-stage fields in, pipeline stall/flush/issue controls out.
// fwd_x/fwd_y exist only when HAZARD_FWD_EN is defined.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [4:0]       id_rd;
    logic             id_wr_en;
    logic             id_is_load;
    logic             id_is_halt;
    logic             IsBranchTaken;
    logic             IsStall;
    logic             flush;
    logic             issue;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
`ifdef HAZARD_FWD_EN
    logic [1:0]       fwd_x;
    logic [1:0]       fwd_y;
`endif

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        output id_rd, id_wr_en, id_is_load, id_is_halt, IsBranchTaken,
`ifdef HAZARD_FWD_EN
        input  fwd_x, fwd_y,
`endif
        input  IsStall, flush, issue, halted, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        input  id_rd, id_wr_en, id_is_load, id_is_halt, IsBranchTaken,
`ifdef HAZARD_FWD_EN
        output fwd_x, fwd_y,
`endif
        output IsStall, flush, issue, halted, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// In-order pipeline hazard controller: RAW stalls, branch flush bubbles, HALT drain.
// Define HAZARD_FWD_EN to stall only on load-use and emit fwd_x/fwd_y bypass selects.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES - 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr_en;
        logic       is_load;
    } trk_t;

    function automatic logic src_hit(input trk_t ent, input logic [4:0] src, input logic used);
        return used && (src != 5'd0) && ent.valid && ent.wr_en && (ent.rd == src);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    trk_t             e_q, m_q, w_q, e_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             raw_s, raw_stall_s, stall_s, flush_s, issue_s, run_s;
    logic             unused_ok_s;

    assign run_s       = (state_q == ST_RUN);
    assign unused_ok_s = ^{e_q.is_load, m_q.is_load, w_q.is_load};

    // Hazard detection against the in-flight producers.
    always_comb begin
        raw_s = 1'b0;
`ifdef HAZARD_FWD_EN
        if (e_q.is_load) begin
            raw_s = src_hit(e_q, bus.id_rs, bus.id_rs_used) | src_hit(e_q, bus.id_rt, bus.id_rt_used);
        end else begin
            raw_s = 1'b0;
        end
`else
        raw_s = src_hit(e_q, bus.id_rs, bus.id_rs_used) | src_hit(e_q, bus.id_rt, bus.id_rt_used)
              | src_hit(m_q, bus.id_rs, bus.id_rs_used) | src_hit(m_q, bus.id_rt, bus.id_rt_used)
              | src_hit(w_q, bus.id_rs, bus.id_rs_used) | src_hit(w_q, bus.id_rt, bus.id_rt_used);
`endif
    end

    // Pipeline controls; a taken branch overrides any pending RAW stall.
    always_comb begin
        raw_stall_s = 1'b0;
        flush_s     = 1'b0;
        stall_s     = 1'b0;
        issue_s     = 1'b0;
        if (rst) begin
            raw_stall_s = 1'b0;
        end else begin
            raw_stall_s = raw_s & bus.id_valid & run_s & ~bus.IsBranchTaken;
            flush_s     = (run_s & bus.IsBranchTaken) | (state_q == ST_FLUSH);
            stall_s     = raw_stall_s | (state_q == ST_DRAIN) | (state_q == ST_HALTED);
            issue_s     = bus.id_valid & ~stall_s & ~flush_s & run_s;
        end
    end

    // FSM next state and flush bubble counter.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush_s && (FLUSH_CYCLES > 1)) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FC_INIT;
                end else if (issue_s && bus.id_is_halt) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                fcnt_d = (fcnt_q != {FC_W{1'b0}}) ? fcnt_q - FC_W'(1) : {FC_W{1'b0}};
                if (fcnt_q <= FC_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (!e_q.valid && !m_q.valid && !w_q.valid) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Tracker load and saturating RAW-stall count.
    always_comb begin
        e_d = '0;
        if (issue_s) begin
            e_d = '{valid: 1'b1, rd: bus.id_rd, wr_en: bus.id_wr_en, is_load: bus.id_is_load};
        end else begin
            e_d = '0;
        end
        if (raw_stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= {FC_W{1'b0}};
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            e_q     <= e_d;
            m_q     <= e_q;
            w_q     <= m_q;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input trk_t e, input trk_t m, input logic [4:0] src,
                                           input logic used);
        if (src_hit(e, src, used)) begin
            return 2'd1;
        end else if (src_hit(m, src, used)) begin
            return 2'd2;
        end else begin
            return 2'd0;
        end
    endfunction

    assign bus.fwd_x = fwd_sel(e_q, m_q, bus.id_rs, bus.id_rs_used);
    assign bus.fwd_y = fwd_sel(e_q, m_q, bus.id_rt, bus.id_rt_used);
`endif

    assign bus.IsStall   = stall_s;
    assign bus.flush     = flush_s;
    assign bus.issue     = issue_s;
    assign bus.halted    = (state_q == ST_HALTED);
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_hazard_ctrl;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
    hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } ent_t;

    // Model: pipe[0..2] are the instructions now in EXE, MEM, WB.
    ent_t pipe [3];
    int   mode;        // 0 running, 1 flushing, 2 draining, 3 halted
    int   flush_left;
    int   m_cnt;
    int   n_chk;
    int   n_fail;
    int   c_stall, c_flush, c_issue, c_halted, c_cnt, c_fx, c_fy;
    int   base;

    function automatic bit blocks(input int src, input bit used);
        if (!used || src == 0) return 1'b0;
`ifdef HAZARD_FWD_EN
        return pipe[0].v && pipe[0].we && pipe[0].ld && pipe[0].rd == src;
`else
        for (int k = 0; k < 3; k++) begin
            if (pipe[k].v && pipe[k].we && pipe[k].rd == src) return 1'b1;
        end
        return 1'b0;
`endif
    endfunction

    function automatic int fwd_of(input int src, input bit used);
        if (!used || src == 0) return 0;
        for (int k = 0; k < 2; k++) begin
            if (pipe[k].v && pipe[k].we && pipe[k].rd == src) return k + 1;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input int rs, input bit rsu, input int rt,
                        input bit rtu, input int rd, input bit we, input bit ld, input bit hlt,
                        input bit br);
        bit e_raw, e_flush, e_stall, e_issue, empty;
        rst               = r;
        bus.id_valid      = v;
        bus.id_rs         = 5'(rs);
        bus.id_rt         = 5'(rt);
        bus.id_rs_used    = rsu;
        bus.id_rt_used    = rtu;
        bus.id_rd         = 5'(rd);
        bus.id_wr_en      = we;
        bus.id_is_load    = ld;
        bus.id_is_halt    = hlt;
        bus.IsBranchTaken = br;
        @(negedge clk);
        if (r) begin
            e_raw = 1'b0; e_flush = 1'b0; e_stall = 1'b0; e_issue = 1'b0;
        end else begin
            e_raw   = (blocks(rs, rsu) || blocks(rt, rtu)) && v && mode == 0 && !br;
            e_flush = (mode == 0 && br) || mode == 1;
            e_stall = e_raw || mode >= 2;
            e_issue = v && !e_stall && !e_flush && mode == 0;
        end
        c_stall  = int'(bus.IsStall);
        c_flush  = int'(bus.flush);
        c_issue  = int'(bus.issue);
        c_halted = int'(bus.halted);
        c_cnt    = int'(bus.stall_cnt);
        chk("IsStall", c_stall, int'(e_stall));
        chk("flush", c_flush, int'(e_flush));
        chk("issue", c_issue, int'(e_issue));
        chk("halted", c_halted, int'(mode == 3));
        chk("stall_cnt", c_cnt, m_cnt);
`ifdef HAZARD_FWD_EN
        c_fx = int'(bus.fwd_x);
        c_fy = int'(bus.fwd_y);
        if (!r) begin
            chk("fwd_x", c_fx, fwd_of(rs, rsu));
            chk("fwd_y", c_fy, fwd_of(rt, rtu));
        end
`endif
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
            mode = 0; flush_left = 0; m_cnt = 0;
        end else begin
            empty = !pipe[0].v && !pipe[1].v && !pipe[2].v;
            if (e_raw && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            case (mode)
                0: begin
                    if (br) begin
                        flush_left = FLUSH_CYCLES - 1;
                        mode = (flush_left > 0) ? 1 : 0;
                    end else if (e_issue && hlt) begin
                        mode = 2;
                    end
                end
                1: begin
                    flush_left--;
                    if (flush_left == 0) mode = 0;
                end
                2: if (empty) mode = 3;
                default: ;
            endcase
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (e_issue) pipe[0] = '{v: 1'b1, rd: rd, we: we, ld: ld};
            else         pipe[0] = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd_r3(input bit br);
        step(1'b0, 1'b1, 3, 1'b1, 4, 1'b1, 6, 1'b1, 1'b0, 1'b0, br);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; c_fx = 0; c_fy = 0;
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_rs_used = 1'b0;
        bus.id_rt_used = 1'b0; bus.id_rd = 5'd0; bus.id_wr_en = 1'b0; bus.id_is_load = 1'b0;
        bus.id_is_halt = 1'b0; bus.IsBranchTaken = 1'b0;
        for (int k = 0; k < 3; k++) pipe[k] = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
        mode = 0; flush_left = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset cycle: even a valid branch must not flush or issue.
        step(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_flush", c_flush, 0);
        chk("rst_issue", c_issue, 0);
        chk("rst_stall", c_stall, 0);
        idle();
        chk("rst_cnt", c_cnt, 0);
        chk("rst_halted", c_halted, 0);

        // ADD r3 then a reader of r3.
        step(1'b0, 1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("add_issue", c_issue, 1);
`ifdef HAZARD_FWD_EN
        rd_r3(1'b0);
        chk("fwd_nostall", c_stall, 0);
        chk("fwd_dep_issue", c_issue, 1);
        chk("fwd_x_exe", c_fx, 1);
        repeat (3) idle();
        step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lw_issue", c_issue, 1);
        step(1'b0, 1'b1, 5, 1'b1, 0, 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("loaduse_stall", c_stall, 1);
        step(1'b0, 1'b1, 5, 1'b1, 0, 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("loaduse_release", c_stall, 0);
        chk("loaduse_issue", c_issue, 1);
        chk("fwd_x_mem", c_fx, 2);
        chk("loaduse_cnt", c_cnt, 1);
`else
        for (int k = 0; k < 3; k++) begin
            rd_r3(1'b0);
            chk("raw_stall", c_stall, 1);
            chk("raw_noissue", c_issue, 0);
        end
        rd_r3(1'b0);
        chk("raw_issue4", c_issue, 1);
        chk("raw_stall_off", c_stall, 0);
        chk("raw_cnt3", c_cnt, 3);
`endif

        // Branch resolves while a dependent reader waits.
        repeat (3) idle();
        step(1'b0, 1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        base = c_cnt;
        rd_r3(1'b1);
        chk("br_flush1", c_flush, 1);
        chk("br_nostall1", c_stall, 0);
        chk("br_noissue1", c_issue, 0);
        rd_r3(1'b0);
        chk("br_flush2", c_flush, 1);
        chk("br_nostall2", c_stall, 0);
        rd_r3(1'b0);
        chk("br_flush_end", c_flush, 0);
        chk("br_cnt_same", c_cnt, base);

        // HALT behind two in-flight instructions.
        repeat (3) idle();
        step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("halt_issue", c_issue, 1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("drain_stall", c_stall, 1);
            chk("drain_noissue", c_issue, 0);
            chk("drain_halted", c_halted, 0);
        end
        step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("halted_set", c_halted, 1);
        chk("halted_stall", c_stall, 1);
        step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("halted_hold", c_halted, 1);
        chk("halted_noflush", c_flush, 0);

        // Saturate the counter, then reset in the middle of a flush.
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 3, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        chk("cnt_saturated", c_cnt, 15);
        step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_br_flush", c_flush, 1);
        step(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_in_flush_flush", c_flush, 0);
        chk("rst_in_flush_issue", c_issue, 0);
        step(1'b0, 1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_flush", c_flush, 0);
        chk("post_rst_cnt", c_cnt, 0);
        chk("post_rst_issue", c_issue, 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 199) == 0) || (mode == 3 && $urandom_range(0, 3) == 0);
            step(r, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
